csa_pipe_adder: RTL and testbench
=================================

// Module: csa_pipe_adder
// PURPOSE
//   Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16-bit combinational CSA.
//   Operands are split into BLOCK-bit carry-select blocks and the blocks are spread over STAGES register stages.
//   A valid/ready handshake on the input and output sides lets the block sit directly in streaming datapaths.
//   Adds a subtract mode and full backpressure with in-order, lossless delivery.
// PARAMETERS
//   WIDTH   32  operand/sum width in bits
//   BLOCK   4   carry-select block width in bits; WIDTH % BLOCK == 0 is required
//   STAGES  2   pipeline register stages (latency); (WIDTH/BLOCK) % STAGES == 0 is required
// PORTS
//   clk        in   1      single clock; all state changes on the rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      x/y/cin/sub are valid this cycle
//   in_ready   out  1      block accepts input this cycle; transfer when in_valid && in_ready
//   x          in   WIDTH  operand A
//   y          in   WIDTH  operand B
//   cin        in   1      carry-in; ignored when sub=1
//   sub        in   1      0: s = x + y + cin; 1: s = x + ~y + 1
//   out_valid  out  1      s/cout (and ovf) are valid
//   out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//   s          out  WIDTH  sum / difference
//   cout       out  1      carry-out of MSB (in sub mode 1 = no borrow)
//   ovf        out  1      signed overflow; present only with CSA_OVF_EN
// BEHAVIOUR
//   - Reset: all stage valid bits, out_valid, s, cout, ovf and internal data registers -> 0; in_ready = 1 the cycle after.
//   - Stage k (0..STAGES-1) computes WIDTH/STAGES bits, LSB slice first; each block has sum0/sum1
//     precomputed and is selected by the incoming block carry; the slice carry-out is registered into stage k+1.
//   - Upper, not-yet-added operand slices and sub are carried along in skew registers with each stage.
//   - Effective B = sub ? ~y : y; effective carry-in = sub ? 1 : cin; inversion applied at stage 0 entry.
//   - Latency: exactly STAGES cycles from accepted input to out_valid with out_ready held 1; throughput 1/cycle.
//   - Stage ready: rdy_k = !valid_k || rdy_(k+1); rdy_STAGES = out_ready; in_ready = rdy_0 (combinational path allowed).
//   - Stage k loads from k-1 when rdy_k; valid_k <= valid_(k-1) (stage 0 from in_valid && in_ready).
//   - Internal bubbles collapse; stalled stages hold data and valid unchanged; max STAGES results in flight.
//   - Output stage is the last pipeline register; s/cout/ovf stable while out_valid && !out_ready.
//   - Simultaneous out handshake and in handshake on a full pipe: both complete, occupancy unchanged.
//   - Wrap-around: sum is modulo 2^WIDTH; carry out of bit WIDTH-1 appears only on cout.
//   - Reset mid-operation: all in-flight results discarded; no out_valid until new inputs traverse the pipe.
//   - in_valid ignored (no state change) when in_ready=0; inputs need not be held stable beyond the transfer cycle.
// CONFIGURATION
//   CSA_OVF_EN defined: ovf port exists; ovf = carry into MSB XOR carry out of MSB (effective operands),
//     registered alongside s, reset 0.
//   CSA_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.
// TESTING (defaults WIDTH=32, BLOCK=4, STAGES=2, out_ready=1 unless noted)
//   1 Basic: x=0000_1023, y=0000_0367, cin=0, sub=0 -> 2 cycles later s=0000_138A, cout=0.
//   2 Cross-stage carry: x=0000_FFFF, y=0000_0001, cin=0 -> s=0001_0000, cout=0; x=FFFF_FFFF, y=0, cin=1 -> s=0, cout=1, ovf=0.
//   3 Sub/overflow: sub=1, x=5, y=7 -> s=FFFF_FFFE, cout=0; sub=0, x=7FFF_FFFF, y=1, cin=0 -> s=8000_0000, ovf=1.
//   4 Backpressure: out_ready=0, stream 4 back-to-back inputs -> exactly 2 accepted, then in_ready=0; raise out_ready
//     -> results in order, none lost or duplicated, remaining inputs then accepted.
//   5 Throughput: 100 random back-to-back vectors, random out_ready -> every result matches reference model, in order.
//   6 Reset mid-op: assert rst for 1 cycle with 2 results in flight -> out_valid=0, s=0, cout=0; no stale output after release.

Source files
------------

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor with valid/ready handshake; CSA_OVF_EN adds the ovf port
module csa_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Bits added per pipeline stage and carry-select blocks inside one stage.
    localparam int SLICE = WIDTH / STAGES;
    localparam int NBLK  = SLICE / BLOCK;

    // One stage slice: every block precomputes sum0 (carry 0) and sum1 (carry 1),
    // the rippling block carry only drives the select muxes.
    function automatic logic [SLICE:0] slice_add(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             c
    );
        logic [SLICE-1:0] sum;
        logic [BLOCK:0]   sum0;
        logic [BLOCK:0]   sum1;
        logic             carry;
        sum   = '0;
        carry = c;
        for (int i = 0; i < NBLK; i++) begin
            sum0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]};
            sum1 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
            sum[i*BLOCK +: BLOCK] = carry ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
            carry = carry ? sum1[BLOCK] : sum0[BLOCK];
        end
        return {carry, sum};
    endfunction

    // Per-stage pipeline registers: valid, slice carry-out, partial sum (low bits
    // finished so far) and skewed effective operands for the slices still to add.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    // Values presented at the entry of each stage (stage 0 from the ports).
    logic [STAGES-1:0] ent_v;
    logic [STAGES-1:0] ent_c;
    logic [WIDTH-1:0]  ent_a [STAGES];
    logic [WIDTH-1:0]  ent_b [STAGES];
    logic [WIDTH-1:0]  ent_s [STAGES];
    logic [SLICE:0]    res   [STAGES];
    logic [STAGES-1:0] rdy;

`ifdef CSA_OVF_EN
    logic ovf_q;
    logic ovf_d;
`endif

    // The last stage's operand copies are never consumed; fold them into a sink.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    // Ready chain from the output back to the input: a stage may load when it is
    // empty or its successor is loading, so bubbles collapse.
    always_comb begin
        logic r;
        rdy = '0;
        r   = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !valid_q[k] || r;
            rdy[k] = r;
        end
    end

    // Stage entry values; subtract inverts B and forces carry-in at stage 0.
    always_comb begin
        ent_v    = '0;
        ent_c    = '0;
        ent_v[0] = in_valid;
        ent_c[0] = sub | cin;
        ent_a[0] = x;
        ent_b[0] = sub ? ~y : y;
        ent_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            ent_v[k] = valid_q[k-1];
            ent_c[k] = carry_q[k-1];
            ent_a[k] = a_q[k-1];
            ent_b[k] = b_q[k-1];
            ent_s[k] = sum_q[k-1];
        end
    end

    // Slice k of the operands is added in stage k, LSB slice first.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res[k] = slice_add(ent_a[k][k*SLICE +: SLICE], ent_b[k][k*SLICE +: SLICE], ent_c[k]);
        end
    end

    // Next-state for each stage: load when ready, otherwise hold data and valid.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = sum_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            if (rdy[k]) begin
                valid_d[k] = ent_v[k];
                if (ent_v[k]) begin
                    a_d[k]                   = ent_a[k];
                    b_d[k]                   = ent_b[k];
                    sum_d[k]                 = ent_s[k];
                    sum_d[k][k*SLICE +: SLICE] = res[k][SLICE-1:0];
                    carry_d[k]               = res[k][SLICE];
                end
            end
        end
    end

`ifdef CSA_OVF_EN
    // Signed overflow: carry into the MSB (a^b^sum at the MSB) XOR carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (rdy[STAGES-1] && ent_v[STAGES-1]) begin
            ovf_d = ent_a[STAGES-1][WIDTH-1] ^ ent_b[STAGES-1][WIDTH-1]
                  ^ res[STAGES-1][SLICE-1] ^ res[STAGES-1][SLICE];
        end
    end
`endif

    // Pipeline registers with synchronous reset clearing all valid and data state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
`ifdef CSA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
`ifdef CSA_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
`ifdef CSA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - self-checking bench for csa_pipe_adder against an arithmetic reference model
module tb_csa_pipe_adder;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef CSA_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Entries are {ovf, cout, s}; ovf is forced to 0 when the port is absent.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] got_q[$];
    logic         obs_ov;
    logic         obs_ir;
    logic         obs_acc;
    logic         obs_cout;
    logic         obs_ovf;
    logic [W-1:0] obs_s;

    csa_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef CSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b_in,
                                                input logic c, input logic sb);
        logic [W-1:0] b;
        logic [W:0]   full;
        logic         v;
        b    = sb ? ~b_in : b_in;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (sb | c)};
        v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`ifndef CSA_OVF_EN
        v = 1'b0;
`endif
        return {v, full};
    endfunction

    // One clock cycle: drive at posedge+1, sample handshakes at posedge+2, end at next posedge+1.
    task automatic cyc(input logic v, input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input logic c, input logic sb, input logic ordy);
        in_valid  = v;
        x         = xa;
        y         = ya;
        cin       = c;
        sub       = sb;
        out_ready = ordy;
        #1;
        obs_ov   = out_valid;
        obs_ir   = in_ready;
        obs_s    = s;
        obs_cout = cout;
`ifdef CSA_OVF_EN
        obs_ovf  = ovf;
`else
        obs_ovf  = 1'b0;
`endif
        obs_acc = in_valid && in_ready && !rst;
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(ref_model(xa, ya, c, sb));
            if (out_valid && out_ready) got_q.push_back({obs_ovf, obs_cout, obs_s});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (s !== '0) begin bad++; $display("FAIL reset_s got=%h want=0", s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic test_basic();
        vec_t tbl[5];
        tbl[0] = '{32'h0000_1023, 32'h0000_0367, 1'b0, 1'b0, 32'h0000_138A, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub, 1'b1);
            total++; if (obs_acc !== 1'b1) begin bad++; $display("FAIL basic%0d_accept got=%b want=1", i, obs_acc); end
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            total++; if (obs_ov !== 1'b0) begin bad++; $display("FAIL basic%0d_early_valid got=%b want=0", i, obs_ov); end
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            total++; if (obs_ov !== 1'b1) begin bad++; $display("FAIL basic%0d_latency got=%b want=1", i, obs_ov); end
            total++; if (obs_s !== tbl[i].s) begin bad++; $display("FAIL basic%0d_s got=%h want=%h", i, obs_s, tbl[i].s); end
            total++; if (obs_cout !== tbl[i].cout) begin bad++; $display("FAIL basic%0d_cout got=%b want=%b", i, obs_cout, tbl[i].cout); end
`ifdef CSA_OVF_EN
            total++; if (obs_ovf !== tbl[i].ovf) begin bad++; $display("FAIL basic%0d_ovf got=%b want=%b", i, obs_ovf, tbl[i].ovf); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vx[4];
        logic [W-1:0] vy[4];
        logic         vc[4];
        logic         vs[4];
        int idx = 0;
        int n   = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) begin
            vx[i] = $urandom; vy[i] = $urandom; vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, vx[idx], vy[idx], vc[idx], vs[idx], 1'b0);
            if (obs_acc) idx++;
            if (c >= 2) begin
                total++; if (obs_s !== exp_q[0][W-1:0]) begin bad++; $display("FAIL bp_stall_s%0d got=%h want=%h", c, obs_s, exp_q[0][W-1:0]); end
            end
        end
        total++; if (idx != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", idx); end
        total++; if (obs_ir !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", obs_ir); end
        cyc(1'b1, vx[idx], vy[idx], vc[idx], vs[idx], 1'b1);
        total++; if (obs_ir !== 1'b1) begin bad++; $display("FAIL bp_full_pass got=%b want=1", obs_ir); end
        if (obs_acc) idx++;
        while ((idx < 4 || got_q.size() < 4) && n < 50) begin
            cyc(idx < 4, vx[idx < 4 ? idx : 3], vy[idx < 4 ? idx : 3], vc[idx < 4 ? idx : 3], vs[idx < 4 ? idx : 3], 1'b1);
            if (obs_acc) idx++;
            n++;
        end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_result%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int n   = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            if (obs_acc) acc++;
        end
        total++; if (acc != 20) begin bad++; $display("FAIL b2b_rate got=%0d want=20", acc); end
        while (got_q.size() < acc && n < 10) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        total++; if (n != 2) begin bad++; $display("FAIL b2b_drain_cycles got=%0d want=2", n); end
        for (int i = 0; i < acc && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_result%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] vx[100];
        logic [W-1:0] vy[100];
        logic         vc[100];
        logic         vs[100];
        int idx = 0;
        int n   = 0;
        int p;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 100; i++) begin
            vx[i] = $urandom; vy[i] = $urandom; vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
        end
        vx[7] = 32'hFFFF_FFFF; vy[7] = 32'h0000_0000; vc[7] = 1'b1; vs[7] = 1'b0;
        vx[8] = 32'h8000_0000; vy[8] = 32'h0000_0001; vs[8] = 1'b1;
        while ((idx < 100 || got_q.size() < 100) && n < 3000) begin
            p = (idx < 100) ? idx : 99;
            cyc(idx < 100, vx[p], vy[p], vc[p], vs[p], (idx < 100) ? 1'($urandom_range(0, 1)) : 1'b1);
            if (obs_acc) idx++;
            n++;
        end
        total++; if (n >= 3000) begin bad++; $display("FAIL rand_timeout got=%0d cycles want<3000", n); end
        total++; if (got_q.size() != 100) begin bad++; $display("FAIL rand_count got=%0d want=100", got_q.size()); end
        for (int i = 0; i < 100 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_result%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midop();
        int acc   = 0;
        int stale = 0;
        int n     = 0;
        exp_q.delete(); got_q.delete();
        cyc(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        if (obs_acc) acc++;
        cyc(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
        if (obs_acc) acc++;
        total++; if (acc != 2) begin bad++; $display("FAIL rst_inflight got=%0d want=2", acc); end
        rst = 1'b1;
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
        total++; if (s !== '0) begin bad++; $display("FAIL rst_mid_s got=%h want=0", s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL rst_mid_cout got=%b want=0", cout); end
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (obs_ov) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL rst_stale got=%0d want=0", stale); end
        cyc(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        while (got_q.size() < 1 && n < 10) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL rst_after_count got=%0d want=1", got_q.size()); end
        total++; if (got_q.size() > 0 && got_q[0] !== {2'b00, 32'h0000_0100}) begin
            bad++; $display("FAIL rst_after_result got=%h want=%h", got_q[0], {2'b00, 32'h0000_0100});
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
